// File: rtl/adder_seq_pkg.sv
// ---------------------------------------------------------------------------
// adder_seq_pkg
//   Shared definitions for the nibble-serial adder sequencer.
//   - SLICE_W         : width of the shared adder slice (4 bits)
//   - state_t         : sequencer FSM states (IDLE, RUN, DONE)
//   - calc_num_slices : number of slice passes needed for a given width
// ---------------------------------------------------------------------------
package adder_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_num_slices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/adder4.sv
// ---------------------------------------------------------------------------
// adder4
//   Plain 4-bit ripple adder slice: {cout, S} = A + B + cin.
//   Ports:
//     A, B  in  4  slice operands
//     cin   in  1  carry-in
//     S     out 4  slice sum
//     cout  out 1  carry-out
// ---------------------------------------------------------------------------
module adder4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] S,
    output logic       cout
);

    assign {cout, S} = 5'(A) + 5'(B) + 5'(cin);

endmodule

// File: rtl/adder4_seq_ctrl.sv
// ---------------------------------------------------------------------------
// adder4_seq_ctrl
//   Adds two WIDTH-bit operands by reusing one adder4 slice over
//   NUM_SLICES = WIDTH/4 cycles, least-significant nibble first. The slice
//   carry-out is registered and fed back as the next slice's carry-in.
//
//   Optional build macro ADDSEQ_SUB_EN adds port 'sub': when set at accept,
//   B is inverted per slice and the carry register starts at 1 (cin ignored),
//   giving a - b with cout=1 meaning "no borrow".
//
//   Ports:
//     clk        in   1      clock, rising edge
//     rst_n      in   1      asynchronous active-low reset
//     in_valid   in   1      operand request valid
//     in_ready   out  1      block can accept a request (IDLE)
//     a, b       in   WIDTH  operands
//     cin        in   1      carry-in into slice 0
//     sub        in   1      subtract select (ADDSEQ_SUB_EN only)
//     out_valid  out  1      result valid (DONE)
//     out_ready  in   1      consumer accepts result
//     sum        out  WIDTH  result
//     cout       out  1      carry-out of the final slice
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. in_ready and out_valid are pure decodes of the state register,
//   so neither depends combinationally on in_valid or out_ready. Once
//   out_valid is high, sum/cout stay stable until the result transfer.
// ---------------------------------------------------------------------------
module adder4_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDSEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    import adder_seq_pkg::*;

    localparam int NUM_SLICES = calc_num_slices(WIDTH);
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $error("adder4_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               sub_q;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // In IDLE in_ready is 1, so in_valid alone means an accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)           state_d = RUN;
            RUN:     if (idx_q == LAST_IDX)  state_d = DONE;
            DONE:    if (out_ready)          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // ---------------- Shared slice ----------------
    // Nibble select by comparison against each constant index keeps every
    // operand bit in use and avoids variable part-selects.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*SLICE_W +: SLICE_W];
                slice_b = b_q[i*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};
            end
        end
    end

    adder4 u_slice (
        .A    (slice_a),
        .B    (slice_b),
        .cin  (carry_q),
        .S    (slice_s),
        .cout (slice_co)
    );

`ifndef ADDSEQ_SUB_EN
    assign sub_q = 1'b0;
`endif

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADDSEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        idx_q <= '0;
`ifdef ADDSEQ_SUB_EN
                        sub_q   <= sub;
                        // Two's complement: ~b plus an initial carry of 1.
                        carry_q <= sub ? 1'b1 : cin;
`else
                        carry_q <= cin;
`endif
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_SLICES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            sum_q[i*SLICE_W +: SLICE_W] <= slice_s;
                        end
                    end
                    carry_q <= slice_co;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q <= slice_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder4_seq_ctrl.sv
module tb_adder4_seq_ctrl;

    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    logic [W:0] exp_q[$];
    logic [W:0] got_log[$];
    logic [W:0] mon_e;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[$];

    adder4_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDSEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [W:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                              input logic rcin, input logic rsub);
        logic [W:0] r;
        if (rsub)
            r = {1'b0, ra} + {1'b0, ~rb} + (W+1)'(1);
        else
            r = {1'b0, ra} + {1'b0, rb} + (W+1)'(rcin);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge rst_n) exp_q.delete();

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                check("result_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("result", 32'({cout, sum}), 32'(mon_e));
                    got_log.push_back({cout, sum});
                end
            end
            if (in_valid && in_ready) begin
                check("accept_while_pending", 32'(exp_q.size()), 32'd0);
                exp_q.push_back(ref_result(a, b, cin, sub));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_in_ready(input string name);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_out_valid(input string name, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (lat >= 20) check({name, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub,
                          input logic [W-1:0] esum, input logic ecout);
        int lat;
        wait_in_ready(name);
        a = ta; b = tb; cin = tcin; sub = tsub;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        wait_out_valid(name, lat);
        check({name, "_latency"}, 32'(lat), 32'(NS));
        check({name, "_sum"}, 32'(sum), 32'(esum));
        check({name, "_cout"}, 32'(cout), 32'(ecout));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int n;
        int ov_cnt;

        vecs.push_back('{a:16'h1234, b:16'h4321, cin:1'b0, sub:1'b0, exp_sum:16'h5555, exp_cout:1'b0});
        vecs.push_back('{a:16'hFFFF, b:16'h0001, cin:1'b0, sub:1'b0, exp_sum:16'h0000, exp_cout:1'b1});
        vecs.push_back('{a:16'hFFFF, b:16'hFFFF, cin:1'b1, sub:1'b0, exp_sum:16'hFFFF, exp_cout:1'b1});
        vecs.push_back('{a:16'h0F0F, b:16'h00F1, cin:1'b1, sub:1'b0, exp_sum:16'h1001, exp_cout:1'b0});
`ifdef ADDSEQ_SUB_EN
        vecs.push_back('{a:16'h0005, b:16'h0007, cin:1'b0, sub:1'b1, exp_sum:16'hFFFE, exp_cout:1'b0});
        vecs.push_back('{a:16'h0007, b:16'h0005, cin:1'b0, sub:1'b1, exp_sum:16'h0002, exp_cout:1'b1});
        vecs.push_back('{a:16'h1000, b:16'h1000, cin:1'b0, sub:1'b1, exp_sum:16'h0000, exp_cout:1'b1});
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven directed vectors.
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // Backpressure in DONE with in_valid pulsed, then a request held
        // through the result handshake.
        wait_in_ready("bp");
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid("bp", lat);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp_sum_stable", 32'(sum), 32'h3333);
            check("bp_cout_stable", 32'(cout), 32'd0);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid_high", 32'(out_valid), 32'd1);
        end
        a = 16'h0003; b = 16'h0004; cin = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_accepted", 32'(in_ready), 32'd0);
        wait_out_valid("bp_next", lat);
        check("bp_next_sum", 32'(sum), 32'h0007);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during RUN after two slice passes.
        wait_in_ready("rst");
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ov_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        out_ready = 1'b0;
        check("midrun_rst_no_result", 32'(ov_cnt), 32'd0);
        run_op("after_rst", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0);

        // Back-to-back with in_valid held high.
        got_log.delete();
        out_ready = 1'b1;
        wait_in_ready("b2b");
        a = 16'h0100; b = 16'h0100; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 16'h8000; b = 16'h8000;
        wait_in_ready("b2b_second");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (got_log.size() < 2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("b2b_count", 32'(got_log.size()), 32'd2);
        if (got_log.size() >= 2) begin
            check("b2b_first", 32'(got_log[0]), 32'h00200);
            check("b2b_second", 32'(got_log[1]), 32'h10000);
        end
        out_ready = 1'b0;

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 2) == 0);
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom_range(0, 1));
`ifdef ADDSEQ_SUB_EN
            sub       = 1'($urandom_range(0, 1));
`endif
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
